// File: rtl/prog_mealy_fsm_pkg.sv
// Shared types and width helpers for the table-programmable Mealy FSM.
// Table entries are stored at maximum field width; unused upper bits stay zero.
package prog_mealy_fsm_pkg;

  localparam int MAX_SW    = 8;
  localparam int MAX_OUT_W = 16;

  // Bit positions inside the per-cycle error-cause vector.
  localparam int ERR_CFG_ADDR   = 0;
  localparam int ERR_NEXT_RANGE = 1;
  localparam int ERR_CAUSES     = 2;

  typedef struct packed {
    logic [MAX_SW-1:0]    next;
    logic [MAX_OUT_W-1:0] out;
  } tbl_entry_t;

  function automatic int calc_sw(input int num_states);
    int w;
    w = $clog2(num_states);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int calc_aw(input int num_states, input int in_w);
    return calc_sw(num_states) + in_w;
  endfunction

endpackage

// File: rtl/prog_mealy_fsm_tbl.sv
// Transition/output table for prog_mealy_fsm. It holds one entry per {state, input} pair.
// The table has an async clear to {RESET_STATE, 0}, one write port and one combinational read port.
module mealy_tbl
  import prog_mealy_fsm_pkg::*;
#(
  parameter int NUM_STATES  = 5,
  parameter int IN_W        = 2,
  parameter int RESET_STATE = 0,
  parameter int AW          = calc_aw(NUM_STATES, IN_W)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  tbl_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output tbl_entry_t    rdata_o
);

  localparam int         DEPTH     = NUM_STATES << IN_W;
  localparam tbl_entry_t CLR_ENTRY = '{next: MAX_SW'(RESET_STATE), out: '0};

  tbl_entry_t mem_q [DEPTH];

  // Callers only present writes whose state field is legal, so waddr_i < DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= CLR_ENTRY;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_mealy_fsm.sv
// Table-programmable Mealy FSM with input qualification, illegal-next recovery and sticky err.
// Define MEALY_OUT_REG_EN to register fsm_output/out_valid (one cycle later, aligned with cur_state).
module prog_mealy_fsm
  import prog_mealy_fsm_pkg::*;
#(
  parameter int  NUM_STATES  = 5,
  parameter int  IN_W        = 2,
  parameter int  OUT_W       = 2,
  parameter int  RESET_STATE = 0,
  localparam int SW          = calc_sw(NUM_STATES),
  localparam int AW          = SW + IN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  fsm_input,
  output logic [OUT_W-1:0] fsm_output,
  output logic             out_valid,
  output logic [SW-1:0]    cur_state,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [SW-1:0]    cfg_next,
  input  logic [OUT_W-1:0] cfg_out,
  output logic             err,
  input  logic             err_clr
);

  // One spare bit so a limit of 256 is representable in the range compares.
  localparam int              LW       = MAX_SW + 1;
  localparam logic [LW-1:0]   NS_LIMIT = LW'(NUM_STATES);
  localparam logic [SW-1:0]   RST_ST   = SW'(RESET_STATE);

  logic [SW-1:0]         state_q, state_d;
  logic                  err_q, err_d;
  logic [ERR_CAUSES-1:0] err_cause;
  logic [SW-1:0]         cfg_state;
  logic                  wr_ok;
  logic                  next_bad;
  logic [OUT_W-1:0]      step_out;
  tbl_entry_t            wr_ent;
  tbl_entry_t            rd_ent;
  logic                  unused_rd_out_bits;

  assign cfg_state = cfg_addr[AW-1:IN_W];
  assign wr_ok     = (LW'(cfg_state) < NS_LIMIT);

  always_comb begin
    wr_ent      = '0;
    wr_ent.next = MAX_SW'(cfg_next);
    wr_ent.out  = MAX_OUT_W'(cfg_out);
  end

  mealy_tbl #(
    .NUM_STATES  (NUM_STATES),
    .IN_W        (IN_W),
    .RESET_STATE (RESET_STATE),
    .AW          (AW)
  ) u_tbl (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (cfg_we && wr_ok),
    .waddr_i (cfg_addr),
    .wdata_i (wr_ent),
    .raddr_i ({state_q, fsm_input}),
    .rdata_o (rd_ent)
  );

  // Upper out bits are always zero (writes zero-extend); fold them so nothing dangles.
  assign unused_rd_out_bits = ^rd_ent.out;
  assign next_bad           = (LW'(rd_ent.next) >= NS_LIMIT);

  always_comb begin
    state_d   = state_q;
    err_cause = '0;
    step_out  = '0;
    if (in_valid) begin
      step_out = rd_ent.out[OUT_W-1:0];
      if (next_bad) begin
        state_d                   = RST_ST;
        err_cause[ERR_NEXT_RANGE] = 1'b1;
      end else begin
        state_d = rd_ent.next[SW-1:0];
      end
    end
    if (cfg_we && !wr_ok) begin
      err_cause[ERR_CFG_ADDR] = 1'b1;
    end
    // A new error in the same cycle as err_clr keeps the flag set.
    err_d = err_q;
    if (|err_cause) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_ST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign cur_state = state_q;
  assign err       = err_q;

`ifdef MEALY_OUT_REG_EN
  logic [OUT_W-1:0] out_q;
  logic             vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= step_out;
      vld_q <= in_valid;
    end
  end

  assign fsm_output = out_q;
  assign out_valid  = vld_q;
`else
  assign fsm_output = step_out;
  assign out_valid  = in_valid;
`endif

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Self-checking bench for prog_mealy_fsm: directed scenarios plus randomized traffic
// checked every cycle against an array-based behavioural model.
module tb_prog_mealy_fsm;

  localparam int NS = 5;
  localparam int IW = 2;
  localparam int OW = 2;
  localparam int SW = 3;
  localparam int AW = 5;
  localparam int NE = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [IW-1:0] fsm_input = '0;
  logic [OW-1:0] fsm_output;
  logic          out_valid;
  logic [SW-1:0] cur_state;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [SW-1:0] cfg_next = '0;
  logic [OW-1:0] cfg_out = '0;
  logic          err;
  logic          err_clr = 1'b0;

  prog_mealy_fsm #(
    .NUM_STATES  (NS),
    .IN_W        (IW),
    .OUT_W       (OW),
    .RESET_STATE (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .fsm_input  (fsm_input),
    .fsm_output (fsm_output),
    .out_valid  (out_valid),
    .cur_state  (cur_state),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_next   (cfg_next),
    .cfg_out    (cfg_out),
    .err        (err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: entry index = state * 2^IN_W + input.
  int m_next [NE];
  int m_out  [NE];
  int m_state;
  int m_err;
  int m_rout;
  int m_rvld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_next[i] = 0;
      m_out[i]  = 0;
    end
    m_state = 0;
    m_err   = 0;
    m_rout  = 0;
    m_rvld  = 0;
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int idx;
    int cout;
    int set_err;
    if (reset) begin
      model_reset();
      return;
    end
    idx     = m_state * (1 << IW) + int'(fsm_input);
    cout    = in_valid ? m_out[idx] : 0;
    set_err = 0;
    if (in_valid) begin
      if (m_next[idx] >= NS) begin
        m_state = 0;
        set_err = 1;
      end else begin
        m_state = m_next[idx];
      end
    end
    if (cfg_we) begin
      if ((int'(cfg_addr) >> IW) >= NS) begin
        set_err = 1;
      end else begin
        m_next[int'(cfg_addr)] = int'(cfg_next);
        m_out[int'(cfg_addr)]  = int'(cfg_out);
      end
    end
    if (set_err != 0)   m_err = 1;
    else if (err_clr)   m_err = 0;
    m_rout = cout;
    m_rvld = in_valid ? 1 : 0;
  endtask

  // Per-cycle comparison against the model, mid-cycle while inputs are stable.
  always @(negedge clk) begin
    int e_out;
    int e_vld;
`ifdef MEALY_OUT_REG_EN
    e_out = m_rout;
    e_vld = m_rvld;
`else
    e_vld = in_valid ? 1 : 0;
    e_out = in_valid ? m_out[m_state * (1 << IW) + int'(fsm_input)] : 0;
`endif
    chk("cyc_state", 32'(cur_state), m_state);
    chk("cyc_err", 32'(err), m_err);
    chk("cyc_out", 32'(fsm_output), e_out);
    chk("cyc_vld", 32'(out_valid), e_vld);
  end

  task automatic drive(input int v, input int in, input int we, input int addr,
                       input int nxt, input int o, input int clr);
    in_valid  = (v != 0);
    fsm_input = IW'(in);
    cfg_we    = (we != 0);
    cfg_addr  = AW'(addr);
    cfg_next  = SW'(nxt);
    cfg_out   = OW'(o);
    err_clr   = (clr != 0);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input int addr, input int nxt, input int o);
    drive(0, 0, 1, addr, nxt, o, 0);
    tick();
    idle();
  endtask

  // One valid step with literal expectations for output and resulting state.
  task automatic step_chk(input int in, input int exp_o, input int exp_s);
    drive(1, in, 0, 0, 0, 0, 0);
`ifndef MEALY_OUT_REG_EN
    #1;
    chk("lit_out", 32'(fsm_output), exp_o);
    chk("lit_vld", 32'(out_valid), 1);
`endif
    tick();
    chk("lit_state", 32'(cur_state), exp_s);
`ifdef MEALY_OUT_REG_EN
    chk("lit_out", 32'(fsm_output), exp_o);
    chk("lit_vld", 32'(out_valid), 1);
`endif
    idle();
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and cleared table.
    chk("rst_state", 32'(cur_state), 0);
    chk("rst_out", 32'(fsm_output), 0);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_err", 32'(err), 0);
    step_chk(2, 0, 0);

    // Programmed map: (s0,10)->{s1,01}, (s1,11)->{s3,10}.
    wr(2, 1, 1);
    wr(7, 3, 2);
    step_chk(2, 1, 1);
    step_chk(3, 2, 3);

    // Hold for 4 cycles, then resume from the held state.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_state", 32'(cur_state), 3);
      chk("hold_vld", 32'(out_valid), 0);
    end
    wr(13, 2, 3);
    step_chk(1, 3, 2);

    // Out-of-range config address sets the sticky error.
    drive(0, 0, 1, 24, 0, 0, 0);
    tick();
    chk("cfg_err_set", 32'(err), 1);
    idle();
    tick();
    chk("cfg_err_hold", 32'(err), 1);
    drive(0, 0, 1, 24, 0, 0, 1);
    tick();
    chk("cfg_err_setwins", 32'(err), 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("cfg_err_clr", 32'(err), 0);
    chk("cfg_err_state", 32'(cur_state), 2);
    idle();

    // Illegal next field: output still delivered, recover to state 0, err set.
    wr(9, 7, 3);
    step_chk(1, 3, 0);
    chk("next_err", 32'(err), 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    idle();

    // Same-cycle write and step on (s0,00): old entry used now, new one next time.
    wr(0, 0, 1);
    drive(1, 0, 1, 0, 4, 2, 0);
`ifndef MEALY_OUT_REG_EN
    #1;
    chk("coll_old_out", 32'(fsm_output), 1);
`endif
    tick();
    chk("coll_old_state", 32'(cur_state), 0);
`ifdef MEALY_OUT_REG_EN
    chk("coll_old_out", 32'(fsm_output), 1);
`endif
    idle();
    step_chk(0, 2, 4);

    // Mid-run asynchronous reset from state 3 with err set.
    wr(16, 3, 0);
    step_chk(0, 0, 3);
    drive(0, 0, 1, 24, 0, 0, 0);
    tick();
    idle();
    chk("pre_rst_err", 32'(err), 1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_state", 32'(cur_state), 0);
    chk("mid_rst_out", 32'(fsm_output), 0);
    chk("mid_rst_vld", 32'(out_valid), 0);
    chk("mid_rst_err", 32'(err), 0);
    tick();
    reset = 1'b0;
    step_chk(2, 0, 0);

    // Randomized traffic, with one more reset midway.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(9, 0) < 7) ? 1 : 0,
            $urandom_range(3, 0),
            ($urandom_range(9, 0) < 2) ? 1 : 0,
            $urandom_range(31, 0),
            ($urandom_range(9, 0) == 0) ? $urandom_range(7, 5) : $urandom_range(4, 0),
            $urandom_range(3, 0),
            ($urandom_range(9, 0) == 0) ? 1 : 0);
      if (k == 1500) begin
        reset = 1'b1;
        model_reset();
      end
      tick();
      if (k == 1500) reset = 1'b0;
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
